// File: rtl/calc_pkg.sv
// Shared constants and types for the hex calculator controller:
// opcodes, FSM encodings, the decoded key event and a digit-shift helper.
package calc_pkg;

  localparam logic [1:0] ADD      = 2'b00;
  localparam logic [1:0] MULTIPLY = 2'b01;
  localparam logic [1:0] SUBTRACT = 2'b10;

  localparam logic [1:0] ENTER_A  = 2'b00;
  localparam logic [1:0] ENTER_B  = 2'b01;
  localparam logic [1:0] MUL      = 2'b10;
  localparam logic [1:0] RESULT   = 2'b11;

  // One keypress after priority resolution: at most one of eq/hex/op is set.
  typedef struct packed {
    logic       eq;
    logic       hex;
    logic       op;
    logic [3:0] hexcode;
    logic [1:0] opcode;
  } key_t;

  // Bits of the operand that survive a one-digit left shift.
  function automatic int dig_shift_w(input int width);
    return width - 4;
  endfunction

endpackage

// File: rtl/calc_controller_if.sv
// Keypad-side inputs and display-side outputs of the calculator controller.
interface calc_controller_if #(parameter int WIDTH = 16);
  logic             newkey;
  logic             newhex;
  logic [3:0]       hexcode;
  logic             newop;
  logic [1:0]       opcode;
  logic             eq;
  logic [WIDTH-1:0] display;
  logic             busy;
  logic             overflow;
  logic [1:0]       state_out;

  modport master (
    output newkey, newhex, hexcode, newop, opcode, eq,
    input  display, busy, overflow, state_out
  );

  modport slave (
    input  newkey, newhex, hexcode, newop, opcode, eq,
    output display, busy, overflow, state_out
  );
endinterface

// File: rtl/calc_controller_seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles
// after the start edge, with a one-cycle done pulse alongside the final product.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = CW'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/calc_controller.sv
// Hex calculator sequencer: builds operands from digit keys, holds the pending
// operator, evaluates add/sub in one cycle and multiply via seq_multiplier.
module calc_controller
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clock,
  input logic              reset,
  calc_controller_if.slave bus
);
  localparam int SHW = dig_shift_w(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic [1:0]       op_q, op_d;
  logic             dig_seen_q, dig_seen_d;
  logic             ovf_q, ovf_d;
  logic             chain_q, chain_d;
  logic             busy_q, busy_d;

  key_t               key;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res, cur_shift;
  logic               alu_ovf, is_sub, is_mul, do_eval;

  // eq outranks a digit, a digit outranks an operator.
  always_comb begin
    key.eq      = bus.newkey & bus.eq;
    key.hex     = bus.newkey & ~bus.eq & bus.newhex;
    key.op      = bus.newkey & ~bus.eq & ~bus.newhex & bus.newop;
    key.hexcode = bus.hexcode;
    key.opcode  = bus.opcode;
  end

  assign is_sub    = (op_q == SUBTRACT);
  assign is_mul    = (op_q == MULTIPLY);
  assign sum       = {1'b0, acc_q} + {1'b0, cur_q};
  assign diff      = {1'b0, acc_q} - {1'b0, cur_q};
  assign alu_res   = is_sub ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
  assign alu_ovf   = is_sub ? diff[WIDTH] : sum[WIDTH];
  assign cur_shift = {cur_q[SHW-1:0], key.hexcode};
  assign do_eval   = key.eq | (key.op & dig_seen_q);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cur_d      = cur_q;
    disp_d     = disp_q;
    op_d       = op_q;
    dig_seen_d = dig_seen_q;
    ovf_d      = ovf_q;
    chain_d    = chain_q;
    busy_d     = mul_busy;
    mul_start  = 1'b0;
    case (state_q)
      ENTER_A: begin
        if (key.hex) begin
          cur_d      = cur_shift;
          disp_d     = cur_shift;
          dig_seen_d = 1'b1;
        end else if (key.op) begin
          acc_d      = cur_q;
          op_d       = key.opcode;
          cur_d      = '0;
          dig_seen_d = 1'b0;
          state_d    = ENTER_B;
        end
      end
      ENTER_B: begin
        if (key.hex) begin
          cur_d      = cur_shift;
          disp_d     = cur_shift;
          dig_seen_d = 1'b1;
        end else if (do_eval) begin
          if (is_mul) begin
            // Operands are captured by the multiplier now, so cur/op may move on.
            mul_start = 1'b1;
            chain_d   = key.op;
            state_d   = MUL;
          end else begin
            acc_d   = alu_res;
            disp_d  = alu_res;
            ovf_d   = alu_ovf;
            state_d = key.op ? ENTER_B : RESULT;
          end
          if (key.op) begin
            op_d       = key.opcode;
            cur_d      = '0;
            dig_seen_d = 1'b0;
          end
        end else if (key.op) begin
          op_d = key.opcode;
        end
      end
      MUL: begin
        if (mul_done) begin
          acc_d   = mul_prod[WIDTH-1:0];
          disp_d  = mul_prod[WIDTH-1:0];
          ovf_d   = |mul_prod[2*WIDTH-1:WIDTH];
          state_d = chain_q ? ENTER_B : RESULT;
        end
      end
      RESULT: begin
        if (key.hex) begin
          cur_d      = {{SHW{1'b0}}, key.hexcode};
          disp_d     = {{SHW{1'b0}}, key.hexcode};
          dig_seen_d = 1'b1;
          ovf_d      = 1'b0;
          state_d    = ENTER_A;
        end else if (key.op) begin
          op_d       = key.opcode;
          cur_d      = '0;
          dig_seen_d = 1'b0;
          state_d    = ENTER_B;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ENTER_A;
      acc_q      <= '0;
      cur_q      <= '0;
      disp_q     <= '0;
      op_q       <= ADD;
      dig_seen_q <= 1'b0;
      ovf_q      <= 1'b0;
      chain_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      disp_q     <= disp_d;
      op_q       <= op_d;
      dig_seen_q <= dig_seen_d;
      ovf_q      <= ovf_d;
      chain_q    <= chain_d;
      busy_q     <= busy_d;
    end
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (acc_q),
    .b       (cur_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign bus.display   = disp_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = ovf_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller (WIDTH=16): a key/expectation table plus
// hand-written multiply, chaining and mid-multiply reset sequences.
module tb_calc_controller;
  localparam logic [2:0] K_HEX = 3'd0, K_OP = 3'd1, K_EQ = 3'd2, K_RST = 3'd3,
                         K_NOKEY = 3'd4, K_HOP = 3'd5, K_EQH = 3'd6;

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  val;
    logic [15:0] disp;
    logic        ovf;
    logic [1:0]  st;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  vec_t vq[$];

  always #5 clock = ~clock;

  calc_controller_if #(.WIDTH(16)) bus();
  calc_controller #(.WIDTH(16)) dut (.clock(clock), .reset(reset), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_keys();
    bus.newkey = 0; bus.newhex = 0; bus.newop = 0; bus.eq = 0;
    bus.hexcode = 4'h0; bus.opcode = 2'b00;
  endtask

  task automatic apply(input logic [2:0] kind, input logic [3:0] val);
    @(negedge clock);
    case (kind)
      K_HEX:   begin bus.newkey = 1; bus.newhex = 1; bus.hexcode = val; end
      K_OP:    begin bus.newkey = 1; bus.newop = 1; bus.opcode = val[1:0]; end
      K_EQ:    begin bus.newkey = 1; bus.eq = 1; end
      K_RST:   reset = 1;
      K_NOKEY: begin bus.newhex = 1; bus.newop = 1; bus.eq = 1; bus.hexcode = val; end
      K_HOP:   begin bus.newkey = 1; bus.newhex = 1; bus.newop = 1; bus.hexcode = val; bus.opcode = val[1:0]; end
      K_EQH:   begin bus.newkey = 1; bus.eq = 1; bus.newhex = 1; bus.hexcode = val; end
      default: ;
    endcase
    @(posedge clock); #1;
    clear_keys();
    reset = 0;
  endtask

  task automatic idle();
    @(negedge clock);
    @(posedge clock); #1;
  endtask

  // Runs until busy falls; digits may be injected while the multiply is running.
  task automatic wait_mul(input bit inject, input logic [15:0] hold, output int hi, output int fall);
    hi = 0; fall = 0;
    for (int i = 1; i <= 60 && fall == 0; i++) begin
      @(negedge clock);
      if (inject && i >= 2 && i <= 5) begin
        bus.newkey = 1; bus.newhex = 1; bus.hexcode = 4'h9;
      end
      @(posedge clock); #1;
      clear_keys();
      if (i == 8) chk("mul_display_hold", bus.display, hold);
      if (bus.busy) hi++;
      else if (hi > 0) fall = i;
    end
  endtask

  initial begin
    int hi, fall, busy_seen;
    clear_keys();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    repeat (5) idle();
    chk("reset_display", bus.display, 16'h0000);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_overflow", bus.overflow, 1'b0);
    chk("reset_state", bus.state_out, 2'b00);

    vq.push_back('{K_HEX, 4'h1, 16'h0001, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'h2, 16'h0012, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'h3, 16'h0123, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'h4, 16'h1234, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'h5, 16'h2345, 1'b0, 2'd0});
    vq.push_back('{K_RST, 4'h0, 16'h0000, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'hF, 16'h000F, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'hF, 16'h00FF, 1'b0, 2'd0});
    vq.push_back('{K_OP,  4'h0, 16'h00FF, 1'b0, 2'd1});
    vq.push_back('{K_HEX, 4'h0, 16'h0000, 1'b0, 2'd1});
    vq.push_back('{K_HEX, 4'h1, 16'h0001, 1'b0, 2'd1});
    vq.push_back('{K_EQ,  4'h0, 16'h0100, 1'b0, 2'd3});
    vq.push_back('{K_HEX, 4'hF, 16'h000F, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'hF, 16'h00FF, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'hF, 16'h0FFF, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'hF, 16'hFFFF, 1'b0, 2'd0});
    vq.push_back('{K_OP,  4'h0, 16'hFFFF, 1'b0, 2'd1});
    vq.push_back('{K_HEX, 4'h1, 16'h0001, 1'b0, 2'd1});
    vq.push_back('{K_EQ,  4'h0, 16'h0000, 1'b1, 2'd3});
    vq.push_back('{K_HEX, 4'h3, 16'h0003, 1'b0, 2'd0});
    vq.push_back('{K_OP,  4'h2, 16'h0003, 1'b0, 2'd1});
    vq.push_back('{K_HEX, 4'h5, 16'h0005, 1'b0, 2'd1});
    vq.push_back('{K_EQ,  4'h0, 16'hFFFE, 1'b1, 2'd3});
    vq.push_back('{K_HEX, 4'h7, 16'h0007, 1'b0, 2'd0});
    vq.push_back('{K_RST, 4'h0, 16'h0000, 1'b0, 2'd0});
    vq.push_back('{K_HEX, 4'h2, 16'h0002, 1'b0, 2'd0});
    vq.push_back('{K_OP,  4'h0, 16'h0002, 1'b0, 2'd1});
    vq.push_back('{K_HEX, 4'h3, 16'h0003, 1'b0, 2'd1});
    vq.push_back('{K_OP,  4'h0, 16'h0005, 1'b0, 2'd1});
    vq.push_back('{K_HEX, 4'h4, 16'h0004, 1'b0, 2'd1});
    vq.push_back('{K_EQ,  4'h0, 16'h0009, 1'b0, 2'd3});
    vq.push_back('{K_HEX, 4'h2, 16'h0002, 1'b0, 2'd0});
    vq.push_back('{K_OP,  4'h1, 16'h0002, 1'b0, 2'd1});
    vq.push_back('{K_OP,  4'h0, 16'h0002, 1'b0, 2'd1});
    vq.push_back('{K_HEX, 4'h3, 16'h0003, 1'b0, 2'd1});
    vq.push_back('{K_EQ,  4'h0, 16'h0005, 1'b0, 2'd3});
    vq.push_back('{K_OP,  4'h3, 16'h0005, 1'b0, 2'd1});
    vq.push_back('{K_HEX, 4'h1, 16'h0001, 1'b0, 2'd1});
    vq.push_back('{K_EQ,  4'h0, 16'h0006, 1'b0, 2'd3});
    vq.push_back('{K_EQ,  4'h0, 16'h0006, 1'b0, 2'd3});
    vq.push_back('{K_HEX, 4'h9, 16'h0009, 1'b0, 2'd0});
    vq.push_back('{K_EQ,  4'h0, 16'h0009, 1'b0, 2'd0});
    vq.push_back('{K_NOKEY, 4'h5, 16'h0009, 1'b0, 2'd0});
    vq.push_back('{K_HOP, 4'h4, 16'h0094, 1'b0, 2'd0});
    vq.push_back('{K_EQH, 4'h6, 16'h0094, 1'b0, 2'd0});

    foreach (vq[i]) begin
      apply(vq[i].kind, vq[i].val);
      chk($sformatf("vec%0d_display", i), bus.display, vq[i].disp);
      chk($sformatf("vec%0d_overflow", i), bus.overflow, vq[i].ovf);
      chk($sformatf("vec%0d_state", i), bus.state_out, vq[i].st);
      chk($sformatf("vec%0d_busy", i), bus.busy, 1'b0);
    end

    // 12 * 34 with digits pressed while busy.
    apply(K_RST, 0); apply(K_HEX, 1); apply(K_HEX, 2); apply(K_OP, 1);
    apply(K_HEX, 3); apply(K_HEX, 4); apply(K_EQ, 0);
    chk("mul_enter_state", bus.state_out, 2'b10);
    chk("mul_key_edge_busy", bus.busy, 1'b0);
    wait_mul(1'b1, 16'h0034, hi, fall);
    chk("mul_busy_cycles", hi, 16);
    chk("mul_done_edge", fall, 17);
    chk("mul_display", bus.display, 16'h03A8);
    chk("mul_overflow", bus.overflow, 1'b0);
    chk("mul_state", bus.state_out, 2'b11);

    // 03A8 * 0100 overflows into the high half.
    apply(K_OP, 1); apply(K_HEX, 1); apply(K_HEX, 0); apply(K_HEX, 0); apply(K_EQ, 0);
    wait_mul(1'b0, 16'h0100, hi, fall);
    chk("mulovf_display", bus.display, 16'hA800);
    chk("mulovf_overflow", bus.overflow, 1'b1);

    // Operator change before the second operand: 2 + * 3 = 6.
    apply(K_RST, 0); apply(K_HEX, 2); apply(K_OP, 0); apply(K_OP, 1);
    apply(K_HEX, 3); apply(K_EQ, 0);
    wait_mul(1'b0, 16'h0003, hi, fall);
    chk("opchg_display", bus.display, 16'h0006);
    chk("opchg_state", bus.state_out, 2'b11);

    // Chained multiply returns to ENTER_B: 2 * 3 + 1 = 7.
    apply(K_RST, 0); apply(K_HEX, 2); apply(K_OP, 1); apply(K_HEX, 3); apply(K_OP, 0);
    wait_mul(1'b0, 16'h0003, hi, fall);
    chk("chainmul_display", bus.display, 16'h0006);
    chk("chainmul_state", bus.state_out, 2'b01);
    apply(K_HEX, 1); apply(K_EQ, 0);
    chk("chainmul_final", bus.display, 16'h0007);

    // Reset five cycles into a multiply.
    apply(K_RST, 0); apply(K_HEX, 5); apply(K_OP, 1); apply(K_HEX, 5); apply(K_EQ, 0);
    repeat (4) idle();
    chk("midrst_busy_before", bus.busy, 1'b1);
    apply(K_RST, 0);
    chk("midrst_display", bus.display, 16'h0000);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_state", bus.state_out, 2'b00);
    busy_seen = 0;
    repeat (25) begin
      idle();
      if (bus.busy || bus.state_out != 2'b00 || bus.display != 16'h0000) busy_seen++;
    end
    chk("midrst_no_late_done", busy_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Sequencing controller for the four-function hex calculator. It sits directly after keypad_interpreter and consumes its newhex/hexcode, newop/opcode and eq outputs, qualified by the newkey strobe.
- Assembles operands digit by digit, holds the pending operator, and executes add/subtract in one cycle or multiply via an iterative shift-add unit.
- Drives the display value plus busy and overflow flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- newkey  input  1  one-cycle strobe per keypress; other key inputs are ignored when this is 0.
- newhex  input  1  key is a hex digit.
- hexcode  input  4  digit value.
- newop  input  1  key is an operator.
- opcode  input  2  00 add, 01 multiply, 10 subtract; 11 is treated as add.
- eq  input  1  key is equals.
- display  output  WIDTH  value shown: current operand or result.
- busy  output  1  high while a multiply is in progress.
- overflow  output  1  flag for the last result.
- state_out  output  2  current FSM state, for LEDs and debug.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: display=0, busy=0, overflow=0.
  - Internal: acc=0, cur=0, op=ADD, dig_seen=0, state=ENTER_A.
  - Reset asserted during MUL aborts the multiply; busy=0 after that edge.
- A key event is a cycle with newkey=1. Exactly one of newhex/newop/eq is acted on, in priority eq > newhex > newop.
- States: ENTER_A=00, ENTER_B=01, MUL=10, RESULT=11.
- Digit entry (ENTER_A/ENTER_B): cur <= {cur[WIDTH-5:0], hexcode}; dig_seen<=1.
  - Digits beyond WIDTH/4 shift out the top and are lost; no error is flagged.
  - display tracks cur from the edge after the key.
- ENTER_A:
  - newop: acc<=cur, op<=opcode, cur<=0, dig_seen<=0, go to ENTER_B.
  - eq: ignored.
- ENTER_B:
  - newop with dig_seen=0: replaces op only; display unchanged.
  - newop with dig_seen=1: evaluates acc op cur as for eq, then latches the new op.
    - Result goes to acc; cur<=0; dig_seen<=0; state stays ENTER_B, via MUL if the evaluated op is multiply.
  - eq: evaluates acc op cur.
    - dig_seen=0 uses cur=0.
- Evaluation:
  - ADD/SUB: result registered on the edge after the key; state goes to RESULT.
    - display=result, overflow=carry out (add) or borrow, i.e. acc<cur (sub). Result is modulo 2^WIDTH.
  - MULTIPLY: enter MUL and start the multiplier.
    - busy=1 exactly WIDTH cycles.
    - The product low half is registered on edge k+WIDTH+1, where k is the key edge; busy=0 on that same edge.
    - overflow = (high WIDTH bits of product != 0).
    - After MUL, go to RESULT, or back to ENTER_B if the multiply was triggered by a chained operator.
- MUL: all key events are dropped, not queued. display holds the pre-multiply value until completion.
- RESULT:
  - newhex: cur<=hexcode, dig_seen<=1, overflow<=0, go to ENTER_A.
  - newop: acc<=result, op<=opcode, cur<=0, dig_seen<=0, go to ENTER_B.
  - eq: ignored.
- overflow holds until the next evaluation, a digit typed in RESULT, or reset.
- Simultaneous newhex and newop with newkey is resolved by the priority above; none of it is visible outside the newkey cycle.

Decomposition:
- Package calc_pkg holds:
  - opcode constants ADD=2'b00, MULTIPLY=2'b01, SUBTRACT=2'b10;
  - state encodings ENTER_A, ENTER_B, MUL, RESULT;
  - a helper for the digit-shift width.
- One sub-module, seq_multiplier (parameter WIDTH):
  - Ports: clock, reset, start, a, b, busy, done, product[2*WIDTH-1:0].
  - Shift-add, one bit per cycle; done is a 1-cycle pulse.
- Controller holds the FSM, acc/cur/op registers, add/sub logic and flag logic.

Test Plan (WIDTH=16):
- Reset, then hold idle 5 cycles -> display=0x0000, busy=0, overflow=0, state_out=00. Key digits 1,2,3 -> display=0x0123. Continue with 4,5 -> display=0x2345 (top digit lost).
- Sequence FF, +, 01, = -> display=0x0100 one cycle after eq, overflow=0, state_out=11. Then FFFF, +, 0001, = -> 0x0000, overflow=1.
- Sequence 3, -, 5, = -> display=0xFFFE, overflow=1. Then digit 7 -> display=0x0007, overflow=0, state_out=00.
- Sequence 12, *, 34, = -> busy=1 for exactly 16 cycles, display=0x03A8 at edge k+17, overflow=0. Digit keys pressed during busy have no effect.
- Chaining: 2, +, 3, + (display 0x0005, state ENTER_B), 4, = -> 0x0009. Operator change: 2, +, *, 3, = -> 0x0006.
- Mid-operation reset: assert reset 5 cycles into a multiply -> display=0, busy=0, state_out=00 after that edge; no late done effect afterward.
